// File: rtl/seven_segment_scan_controller.sv
// Eight-digit seven-segment scan controller. It steps through the enabled digits.
// Each digit slot is a blanking gap followed by a lit drive phase.
module seven_segment_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  digit_en,
  input  logic [31:0] digits,
  output logic [2:0]  sel,
  output logic [7:0]  AN,
  output logic [3:0]  hex,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    sel_next;
  logic [7:0]    an_next;
  logic [3:0]    hex_next;
  logic          tick_next;

  // First set bit of mask at or above start, wrapping 7 -> 0.
  function automatic logic [2:0] find_enabled(input logic [7:0] mask,
                                              input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    find_enabled = start;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && mask[idx]) begin
        find_enabled = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel;
    tick_next  = 1'b0;
    if (!en || digit_en == 8'h00) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = BLANK;
          cnt_next   = '0;
          sel_next   = find_enabled(digit_en, sel);
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = DRIVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            sel_next   = find_enabled(digit_en, sel + 3'd1);
            tick_next  = (sel_next <= sel);
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
    // Anodes are a pure function of the next registered state, so they never glitch.
    an_next  = (state_next == DRIVE && digit_en[sel_next]) ? ~(8'b1 << sel_next) : 8'hFF;
    hex_next = digits[{sel_next, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 3'd0;
      AN         <= 8'hFF;
      hex        <= digits[3:0];
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sel        <= sel_next;
      AN         <= an_next;
      hex        <= hex_next;
      frame_tick <= tick_next;
    end
  end

endmodule
